// File: rtl/student_iis_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module : student_iis_rx_fifo
//  Stereo I2S / left-justified ADC capture feeding a {L,R} frame FIFO.
//  Optional build macro: IIS_RX_OVERRUN_CNT_EN (dropped-frame counter).
//  Revision: 1.0
// ============================================================================
module student_iis_rx_fifo #(
    parameter int DATA_SIZE  = 16,
    parameter int SLOT_BITS  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          mode_i,
    input  logic                          AC_ADC_SDATA,
    input  logic                          AC_LRCLK,
    input  logic                          LRCLK_Rise,
    input  logic                          LRCLK_Fall,
    input  logic                          BCLK_Rise,
    output logic [DATA_SIZE-1:0]          data_l_o,
    output logic [DATA_SIZE-1:0]          data_r_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overrun_o,
    output logic                          short_o,
    input  logic                          clr_i,
    output logic [7:0]                    overrun_cnt_o
);

    localparam int                 c_CNT_W    = $clog2(SLOT_BITS + 1);
    localparam int                 c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_SLOT_MAX = c_CNT_W'(SLOT_BITS);
    localparam logic [c_CNT_W-1:0] c_I2S_LAST = c_CNT_W'(DATA_SIZE);
    localparam logic [c_CNT_W-1:0] c_LJ_LAST  = c_CNT_W'(DATA_SIZE - 1);
    localparam logic [c_PTR_W:0]   c_DEPTH    = (c_PTR_W + 1)'(FIFO_DEPTH);

    // Serial capture state
    logic [c_CNT_W-1:0]   r_cnt;
    logic [DATA_SIZE-1:0] r_shift;
    logic                 r_mode;
    logic                 r_armed;
    logic                 r_ch_done;
    logic                 r_done;
    logic                 r_done_right;
    logic [DATA_SIZE-1:0] r_hold_l;
    logic                 r_left_ok;

    logic                 w_edge;
    logic                 w_armed_eff;
    logic                 w_mode_eff;
    logic                 w_bit_en;
    logic                 w_in_win;
    logic                 w_last;
    logic                 w_short_evt;
    logic [c_CNT_W-1:0]   w_idx;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [DATA_SIZE-1:0] w_shift_base;

    // An LRCLK edge restarts the channel before any coincident BCLK is counted.
    always_comb begin
        w_edge       = LRCLK_Rise | LRCLK_Fall;
        w_armed_eff  = r_armed | LRCLK_Fall;
        w_mode_eff   = LRCLK_Fall ? mode_i : r_mode;
        w_idx        = w_edge ? '0 : r_cnt;
        w_shift_base = w_edge ? '0 : r_shift;
        w_cnt_nxt    = (w_idx == c_SLOT_MAX) ? c_SLOT_MAX : w_idx + 1'b1;
        if (w_mode_eff) begin
            w_in_win = (w_idx <= c_LJ_LAST);
            w_last   = (w_idx == c_LJ_LAST);
        end else begin
            w_in_win = (w_idx != '0) && (w_idx <= c_I2S_LAST);
            w_last   = (w_idx == c_I2S_LAST);
        end
        w_bit_en    = en_i & w_armed_eff & BCLK_Rise;
        w_short_evt = en_i & r_armed & w_edge & (r_cnt != '0) & ~r_ch_done;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_mode       <= 1'b0;
            r_armed      <= 1'b0;
            r_ch_done    <= 1'b0;
            r_done       <= 1'b0;
            r_done_right <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!en_i) begin
                r_armed <= 1'b0;
            end else begin
                if (LRCLK_Fall) begin
                    r_armed <= 1'b1;
                    r_mode  <= mode_i;
                end
                if (w_edge) begin
                    r_cnt     <= '0;
                    r_shift   <= '0;
                    r_ch_done <= 1'b0;
                end
                if (w_bit_en) begin
                    r_cnt <= w_cnt_nxt;
                    if (w_in_win) begin
                        r_shift <= {w_shift_base[DATA_SIZE-2:0], AC_ADC_SDATA};
                    end
                    if (w_in_win && w_last) begin
                        r_done       <= 1'b1;
                        r_done_right <= AC_LRCLK;
                        r_ch_done    <= 1'b1;
                    end
                end
            end
        end
    end

    // Left sample is parked until its right partner completes in the same frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_l  <= '0;
            r_left_ok <= 1'b0;
        end else begin
            if (r_done && !r_done_right) begin
                r_hold_l <= r_shift;
            end
            if (!en_i || !r_armed || LRCLK_Fall) begin
                r_left_ok <= 1'b0;
            end else if (r_done) begin
                r_left_ok <= ~r_done_right;
            end
        end
    end

    // Frame FIFO
    logic [2*DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]       r_wptr;
    logic [c_PTR_W:0]       r_rptr;
    logic [c_PTR_W:0]       w_level;
    logic [2*DATA_SIZE-1:0] w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push_req;
    logic                   w_push;
    logic                   w_drop;

    always_comb begin
        w_level    = r_wptr - r_rptr;
        w_full     = (w_level == c_DEPTH);
        w_empty    = (w_level == '0);
        w_pop      = ~w_empty & ready_i;
        w_push_req = r_done & r_done_right & r_left_ok & en_i;
        w_push     = w_push_req & (~w_full | w_pop);
        w_drop     = w_push_req & w_full & ~w_pop;
        w_head     = r_mem[r_rptr[c_PTR_W-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[c_PTR_W-1:0]] <= {r_hold_l, r_shift};
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign data_l_o = w_head[2*DATA_SIZE-1:DATA_SIZE];
    assign data_r_o = w_head[DATA_SIZE-1:0];
    assign valid_o  = ~w_empty;
    assign level_o  = w_level;

    // Sticky status; a clear wins over a same-cycle set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_o <= 1'b0;
            short_o   <= 1'b0;
        end else if (clr_i) begin
            overrun_o <= 1'b0;
            short_o   <= 1'b0;
        end else begin
            if (w_drop) begin
                overrun_o <= 1'b1;
            end
            if (w_short_evt) begin
                short_o <= 1'b1;
            end
        end
    end

`ifdef IIS_RX_OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovr_cnt <= 8'h00;
        end else if (clr_i) begin
            r_ovr_cnt <= 8'h00;
        end else if (w_drop && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'h01;
        end
    end

    assign overrun_cnt_o = r_ovr_cnt;
`else
    assign overrun_cnt_o = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_student_iis_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module : tb_student_iis_rx_fifo
//  Randomised codec-frame stimulus checked against a queue-based frame model.
//  Revision: 1.0
// ============================================================================
module tb_student_iis_rx_fifo;

    localparam int DS    = 16;
    localparam int SB    = 32;
    localparam int DEPTH = 4;

    logic                     clk_i;
    logic                     rst_ni;
    logic                     en_i;
    logic                     mode_i;
    logic                     AC_ADC_SDATA;
    logic                     AC_LRCLK;
    logic                     LRCLK_Rise;
    logic                     LRCLK_Fall;
    logic                     BCLK_Rise;
    logic [DS-1:0]            data_l_o;
    logic [DS-1:0]            data_r_o;
    logic                     valid_o;
    logic                     ready_i;
    logic [$clog2(DEPTH):0]   level_o;
    logic                     overrun_o;
    logic                     short_o;
    logic                     clr_i;
    logic [7:0]               overrun_cnt_o;

    int               n_tests;
    int               n_fail;
    int               m_drops;
    logic [2*DS-1:0]  exp_q[$];

    student_iis_rx_fifo #(.DATA_SIZE(DS), .SLOT_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .mode_i(mode_i),
        .AC_ADC_SDATA(AC_ADC_SDATA), .AC_LRCLK(AC_LRCLK),
        .LRCLK_Rise(LRCLK_Rise), .LRCLK_Fall(LRCLK_Fall), .BCLK_Rise(BCLK_Rise),
        .data_l_o(data_l_o), .data_r_o(data_r_o), .valid_o(valid_o),
        .ready_i(ready_i), .level_o(level_o), .overrun_o(overrun_o),
        .short_o(short_o), .clr_i(clr_i), .overrun_cnt_o(overrun_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        LRCLK_Rise = 1'b0;
        LRCLK_Fall = 1'b0;
        BCLK_Rise  = 1'b0;
    endtask

    task automatic pop_one();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    // Serial bit presented at BCLK index k of a channel, from the format rules.
    function automatic logic bit_at(input logic [DS-1:0] s, input logic md, input int k);
        if (md) return (k < DS) ? s[DS-1-k] : 1'($urandom);
        return (k >= 1 && k <= DS) ? s[DS-k] : 1'($urandom);
    endfunction

    task automatic send_channel(input logic right, input logic [DS-1:0] s, input logic md,
                                input int nbits, input logic eb, input logic fall);
        int start;
        AC_LRCLK = right;
        if (fall) LRCLK_Fall = 1'b1;
        else      LRCLK_Rise = 1'b1;
        start = 0;
        if (eb) begin
            BCLK_Rise    = 1'b1;
            AC_ADC_SDATA = bit_at(s, md, 0);
            start        = 1;
        end
        tick();
        for (int k = start; k < nbits; k++) begin
            tick();
            BCLK_Rise    = 1'b1;
            AC_ADC_SDATA = bit_at(s, md, k);
            tick();
        end
    endtask

    task automatic send_frame(input logic [DS-1:0] l, input logic [DS-1:0] r,
                              input logic md, input logic eb);
        mode_i = md;
        send_channel(1'b0, l, md, SB, eb, 1'b1);
        mode_i = 1'($urandom);
        send_channel(1'b1, r, md, SB, eb, 1'b0);
    endtask

    task automatic model_frame(input logic [DS-1:0] l, input logic [DS-1:0] r);
        if (exp_q.size() < DEPTH) exp_q.push_back({l, r});
        else m_drops++;
    endtask

    task automatic test_reset();
        n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        n_tests++; if (level_o !== '0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", level_o); end
        n_tests++; if ({data_l_o, data_r_o} !== '0) begin n_fail++; $display("FAIL rst_data: got %h/%h want 0", data_l_o, data_r_o); end
        n_tests++; if ({overrun_o, short_o} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b%b want 00", overrun_o, short_o); end
        n_tests++; if (overrun_cnt_o !== 8'h00) begin n_fail++; $display("FAIL rst_cnt: got %h want 00", overrun_cnt_o); end
        rst_ni = 1'b1;
        en_i   = 1'b1;
        tick();
    endtask

    task automatic test_i2s_basic();
        send_frame(16'hA5C3, 16'h0F0F, 1'b0, 1'b0);
        model_frame(16'hA5C3, 16'h0F0F);
        n_tests++; if (level_o !== 1 || valid_o !== 1'b1) begin n_fail++; $display("FAIL i2s_level: got %0d/%b want 1/1", level_o, valid_o); end
        n_tests++; if ({data_l_o, data_r_o} !== exp_q[0]) begin n_fail++; $display("FAIL i2s_data: got %h/%h want %h", data_l_o, data_r_o, exp_q[0]); end
        void'(exp_q.pop_front());
        pop_one();
        n_tests++; if (level_o !== 0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL i2s_empty: got %0d/%b want 0/0", level_o, valid_o); end
        n_tests++; if (short_o !== 1'b0) begin n_fail++; $display("FAIL i2s_short: got %b want 0", short_o); end
    endtask

    task automatic test_lj_edge();
        send_frame(16'h8001, 16'h7FFE, 1'b1, 1'b1);
        model_frame(16'h8001, 16'h7FFE);
        n_tests++; if ({data_l_o, data_r_o} !== 32'h8001_7FFE || valid_o !== 1'b1) begin n_fail++; $display("FAIL lj_data: got %h/%h v=%b want 80017ffe", data_l_o, data_r_o, valid_o); end
        void'(exp_q.pop_front());
        pop_one();
        n_tests++; if (level_o !== 0) begin n_fail++; $display("FAIL lj_empty: got %0d want 0", level_o); end
    endtask

    task automatic test_latency();
        logic [DS-1:0] l, r;
        l = DS'($urandom);
        r = DS'($urandom);
        mode_i = 1'b0;
        send_channel(1'b0, l, 1'b0, SB, 1'b0, 1'b1);
        send_channel(1'b1, r, 1'b0, DS + 1, 1'b0, 1'b0);
        model_frame(l, r);
        n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b want 0 one cycle after last bit", valid_o); end
        tick();
        n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b want 1 two cycles after last bit", valid_o); end
        n_tests++; if ({data_l_o, data_r_o} !== exp_q[0]) begin n_fail++; $display("FAIL lat_data: got %h/%h want %h", data_l_o, data_r_o, exp_q[0]); end
        void'(exp_q.pop_front());
        pop_one();
    endtask

    task automatic test_back_to_back();
        logic [DS-1:0] l, r;
        for (int f = 0; f < 3; f++) begin
            l = DS'($urandom);
            r = DS'($urandom);
            send_frame(l, r, 1'($urandom), 1'($urandom));
            model_frame(l, r);
        end
        n_tests++; if (level_o !== 3) begin n_fail++; $display("FAIL b2b_level: got %0d want 3", level_o); end
        while (exp_q.size() > 0) begin
            n_tests++;
            if ({data_l_o, data_r_o} !== exp_q[0] || valid_o !== 1'b1) begin
                n_fail++; $display("FAIL b2b_pop: got %h/%h v=%b want %h", data_l_o, data_r_o, valid_o, exp_q[0]);
            end
            void'(exp_q.pop_front());
            pop_one();
        end
    endtask

    task automatic test_short();
        mode_i = 1'b0;
        send_channel(1'b0, DS'($urandom), 1'b0, 10, 1'b0, 1'b1);
        send_channel(1'b1, DS'($urandom), 1'b0, SB, 1'b0, 1'b0);
        n_tests++; if (short_o !== 1'b1) begin n_fail++; $display("FAIL short_set: got %b want 1", short_o); end
        n_tests++; if (level_o !== 0) begin n_fail++; $display("FAIL short_nopush: got %0d want 0", level_o); end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        n_tests++; if (short_o !== 1'b0) begin n_fail++; $display("FAIL short_clr: got %b want 0", short_o); end
    endtask

    task automatic test_overrun();
        logic [DS-1:0] l, r;
        logic [7:0]    exp_cnt;
        for (int f = 0; f < 5; f++) begin
            l = DS'($urandom);
            r = DS'($urandom);
            send_frame(l, r, 1'($urandom), 1'b0);
            model_frame(l, r);
        end
`ifdef IIS_RX_OVERRUN_CNT_EN
        exp_cnt = (m_drops > 255) ? 8'd255 : 8'(m_drops);
`else
        exp_cnt = 8'd0;
`endif
        n_tests++; if (level_o !== DEPTH) begin n_fail++; $display("FAIL ovr_level: got %0d want %0d", level_o, DEPTH); end
        n_tests++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun_o); end
        n_tests++; if (overrun_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL ovr_cnt: got %0d want %0d", overrun_cnt_o, exp_cnt); end
        clr_i = 1'b1;
        tick();
        clr_i   = 1'b0;
        m_drops = 0;
        n_tests++; if (overrun_o !== 1'b0 || overrun_cnt_o !== 8'h00) begin n_fail++; $display("FAIL ovr_clr: got %b/%0d want 0/0", overrun_o, overrun_cnt_o); end
    endtask

    task automatic test_full_pop();
        logic [DS-1:0] l, r;
        l = DS'($urandom);
        r = DS'($urandom);
        mode_i = 1'b0;
        send_channel(1'b0, l, 1'b0, SB, 1'b0, 1'b1);
        send_channel(1'b1, r, 1'b0, DS + 1, 1'b0, 1'b0);
        n_tests++; if ({data_l_o, data_r_o} !== exp_q[0]) begin n_fail++; $display("FAIL full_head: got %h/%h want %h", data_l_o, data_r_o, exp_q[0]); end
        void'(exp_q.pop_front());
        exp_q.push_back({l, r});
        pop_one();
        n_tests++; if (level_o !== DEPTH) begin n_fail++; $display("FAIL full_level: got %0d want %0d", level_o, DEPTH); end
        n_tests++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL full_ovr: got %b want 0", overrun_o); end
        while (exp_q.size() > 0) begin
            n_tests++;
            if ({data_l_o, data_r_o} !== exp_q[0] || valid_o !== 1'b1) begin
                n_fail++; $display("FAIL full_pop: got %h/%h v=%b want %h", data_l_o, data_r_o, valid_o, exp_q[0]);
            end
            void'(exp_q.pop_front());
            pop_one();
        end
    endtask

    task automatic test_enable();
        logic [DS-1:0] l, r;
        en_i = 1'b0;
        send_frame(DS'($urandom), DS'($urandom), 1'b0, 1'b0);
        n_tests++; if (level_o !== 0) begin n_fail++; $display("FAIL en_off: got %0d want 0", level_o); end
        mode_i = 1'b0;
        send_channel(1'b0, DS'($urandom), 1'b0, SB, 1'b0, 1'b1);
        en_i = 1'b1;
        send_channel(1'b1, DS'($urandom), 1'b0, SB, 1'b0, 1'b0);
        n_tests++; if (level_o !== 0 || short_o !== 1'b0) begin n_fail++; $display("FAIL en_resume: got %0d/%b want 0/0", level_o, short_o); end
        l = DS'($urandom);
        r = DS'($urandom);
        send_frame(l, r, 1'b1, 1'b0);
        model_frame(l, r);
        n_tests++; if ({data_l_o, data_r_o} !== exp_q[0] || level_o !== 1) begin n_fail++; $display("FAIL en_capture: got %h/%h lvl=%0d want %h lvl=1", data_l_o, data_r_o, level_o, exp_q[0]); end
        void'(exp_q.pop_front());
        pop_one();
    endtask

    task automatic test_reset_mid();
        logic [DS-1:0] l, r;
        send_frame(DS'($urandom), DS'($urandom), 1'b0, 1'b0);
        mode_i = 1'b0;
        send_channel(1'b0, DS'($urandom), 1'b0, SB, 1'b0, 1'b1);
        send_channel(1'b1, DS'($urandom), 1'b0, 5, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        exp_q.delete();
        m_drops = 0;
        n_tests++; if (level_o !== 0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_level: got %0d/%b want 0/0", level_o, valid_o); end
        n_tests++; if ({data_l_o, data_r_o} !== '0 || {overrun_o, short_o} !== 2'b00) begin n_fail++; $display("FAIL rmid_out: got %h/%h %b%b want 0", data_l_o, data_r_o, overrun_o, short_o); end
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        l = DS'($urandom);
        r = DS'($urandom);
        send_frame(l, r, 1'b0, 1'b1);
        model_frame(l, r);
        n_tests++; if ({data_l_o, data_r_o} !== exp_q[0] || level_o !== 1) begin n_fail++; $display("FAIL rmid_frame: got %h/%h lvl=%0d want %h lvl=1", data_l_o, data_r_o, level_o, exp_q[0]); end
        void'(exp_q.pop_front());
        pop_one();
        n_tests++; if (short_o !== 1'b0) begin n_fail++; $display("FAIL rmid_short: got %b want 0", short_o); end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        m_drops      = 0;
        rst_ni       = 1'b0;
        en_i         = 1'b0;
        mode_i       = 1'b0;
        AC_ADC_SDATA = 1'b0;
        AC_LRCLK     = 1'b0;
        LRCLK_Rise   = 1'b0;
        LRCLK_Fall   = 1'b0;
        BCLK_Rise    = 1'b0;
        ready_i      = 1'b0;
        clr_i        = 1'b0;
        repeat (3) tick();
        test_reset();
        test_i2s_basic();
        test_lj_edge();
        test_latency();
        test_back_to_back();
        test_short();
        test_overrun();
        test_full_pop();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
